// File: rtl/dec_seq_pkg.sv
// Shared types and helpers for the dec_seq registered one-hot decoder.
// The onehot helper is sized for the largest supported select width (MAX_N).
package dec_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  // Output width for the default select width; instances derive their own as 1 << N.
  localparam int DEF_N = 2;
  localparam int DEF_W = 1 << DEF_N;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] s);
    logic [MAX_W-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_seq_dwell.sv
// Loadable dwell down-counter for the dec_seq scan sequencer.
// Load wins over counting; the count stops at zero and tc flags zero.
module dec_seq_dwell #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         pause,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!pause && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/dec_seq.sv
// Registered N-to-2^N one-hot decoder with enable; the auto-scan sequencer
// is built only when DEC_SEQ_SCAN_EN is defined, otherwise direct decode only.
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int N          = 2,
  parameter int DWELL_W    = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       sel,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  y,
  output logic [N-1:0]       idx,
  output logic               valid,
  output logic               wrap
);

  localparam int W = 1 << N;
  // Polarity is folded into the output register, so reset lands on the idle level.
  localparam logic [W-1:0] POL = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

  logic [W-1:0] y_q, y_raw;
  logic [N-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;

`ifdef DEC_SEQ_SCAN_EN
  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_val;
  logic                 cnt_load, cnt_pause, tc;
  logic [N-1:0]         idx_inc;

  assign idx_inc = idx_q + 1'b1;

  dec_seq_dwell #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .pause    (cnt_pause),
    .load_val (cnt_val),
    .tc       (tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = dwell_q;
    cnt_pause = 1'b1;
    case (state_q)
      IDLE: begin
        if (mode) begin
          // Armed for scan but not started: outputs stay deasserted, idx holds.
          if (load && en) begin
            state_d  = RUN;
            idx_d    = sel;
            dwell_d  = dwell;
            cnt_load = 1'b1;
            cnt_val  = dwell;
            valid_d  = 1'b1;
          end
        end else begin
          idx_d   = sel;
          valid_d = en;
        end
      end
      RUN: begin
        if (!mode) begin
          state_d = IDLE;
          idx_d   = sel;
          valid_d = en;
        end else if (en) begin
          valid_d = 1'b1;
          if (load) begin
            idx_d    = sel;
            dwell_d  = dwell;
            cnt_load = 1'b1;
            cnt_val  = dwell;
          end else if (tc) begin
            idx_d    = idx_inc;
            cnt_load = 1'b1;
            wrap_d   = (idx_q == {N{1'b1}});
          end else begin
            cnt_pause = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    y_raw = valid_d ? W'(onehot(MAX_N'(idx_d))) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end
`else
  logic [W-1:0] oh_sel;
  logic         unused_scan_inputs;

  assign oh_sel             = W'(onehot(MAX_N'(sel)));
  assign unused_scan_inputs = ^{mode, load, dwell};

  always_comb begin
    idx_d   = sel;
    valid_d = en;
    wrap_d  = 1'b0;
    y_raw   = en ? oh_sel : '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= POL;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      y_q     <= y_raw ^ POL;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_dec_seq.sv
// Scoreboard bench for dec_seq: N=2 active-high instance plus N=3 ACTIVE_LOW instance.
// Scan vectors are exercised when DEC_SEQ_SCAN_EN is defined.
module tb_dec_seq;

  logic       clk, rst, en, mode, load;
  logic [1:0] sel;
  logic [3:0] dwell;
  logic [3:0] y;
  logic [1:0] idx;
  logic       valid, wrap;

  logic       mode3, load3;
  logic [2:0] sel3;
  logic [3:0] dwell3;
  logic [7:0] y3;
  logic [2:0] idx3;
  logic       valid3, wrap3;

  typedef struct {
    logic [3:0] y;
    logic [1:0] idx;
    logic       v;
    logic       w;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       v3;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  dec_seq #(.N(2), .DWELL_W(4), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .dwell(dwell), .y(y), .idx(idx), .valid(valid), .wrap(wrap)
  );

  dec_seq #(.N(3), .DWELL_W(4), .ACTIVE_LOW(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode3), .sel(sel3), .load(load3),
    .dwell(dwell3), .y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic e, input logic m, input logic l, input logic [1:0] s,
                      input logic [3:0] d, input logic [3:0] ey, input logic [1:0] ei,
                      input logic ev, input logic ew);
    exp_t x;
    @(negedge clk);
    en = e; mode = m; load = l; sel = s; dwell = d;
    x.y = ey; x.idx = ei; x.v = ev; x.w = ew;
    x.y3 = e ? 8'hDF : 8'hFF;
    x.idx3 = 3'd5;
    x.v3 = e;
    exp_q.push_back(x);
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if ({y, idx, valid, wrap} !== 8'h00) begin
      failures++;
      $display("FAIL %s dut2 got y=%b idx=%0d valid=%b wrap=%b want y=0000 idx=0 valid=0 wrap=0",
               tag, y, idx, valid, wrap);
    end
    checks++;
    if ({y3, idx3, valid3, wrap3} !== {8'hFF, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s dut3 got y=%b idx=%0d valid=%b wrap=%b want y=11111111 idx=0 valid=0 wrap=0",
               tag, y3, idx3, valid3, wrap3);
    end
  endtask

  // Monitor: compare queued expectations one cycle after each active edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        txn++;
        $display("txn %0d: y=%b idx=%0d valid=%b wrap=%b | y3=%b idx3=%0d valid3=%b",
                 txn, y, idx, valid, wrap, y3, idx3, valid3);
        checks++;
        if ({y, idx, valid, wrap} !== {x.y, x.idx, x.v, x.w}) begin
          failures++;
          $display("FAIL txn%0d dut2 got y=%b idx=%0d valid=%b wrap=%b want y=%b idx=%0d valid=%b wrap=%b",
                   txn, y, idx, valid, wrap, x.y, x.idx, x.v, x.w);
        end
        checks++;
        if ({y3, idx3, valid3, wrap3} !== {x.y3, x.idx3, x.v3, 1'b0}) begin
          failures++;
          $display("FAIL txn%0d dut3 got y=%b idx=%0d valid=%b wrap=%b want y=%b idx=%0d valid=%b wrap=0",
                   txn, y3, idx3, valid3, wrap3, x.y3, x.idx3, x.v3);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel = 2'd0; dwell = 4'd0;
    mode3 = 1'b0; load3 = 1'b0; sel3 = 3'd5; dwell3 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // Direct decode, en toggling, load ignored with mode=0.
    step(1, 0, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
    step(1, 0, 0, 2'd1, 4'd0, 4'b0010, 2'd1, 1, 0);
    step(1, 0, 0, 2'd2, 4'd0, 4'b0100, 2'd2, 1, 0);
    step(1, 0, 0, 2'd3, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(0, 0, 0, 2'd3, 4'd0, 4'b0000, 2'd3, 0, 0);
    step(0, 0, 0, 2'd1, 4'd0, 4'b0000, 2'd1, 0, 0);
    step(1, 0, 1, 2'd2, 4'd1, 4'b0100, 2'd2, 1, 0);
    step(1, 0, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);

`ifdef DEC_SEQ_SCAN_EN
    // Scan from 2, dwell=1: 2,2,3,3,0,0,1,1,2 with wrap on the 3->0 step.
    step(1, 1, 1, 2'd2, 4'd1, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 1);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    // mode falls: direct decode resumes.
    step(1, 0, 0, 2'd3, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 0, 0, 2'd1, 4'd0, 4'b0010, 2'd1, 1, 0);
    // Scan from 3 with dwell=0, pause for three cycles.
    step(1, 1, 1, 2'd3, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 1);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    step(0, 1, 0, 2'd0, 4'd0, 4'b0000, 2'd1, 0, 0);
    step(0, 1, 0, 2'd0, 4'd0, 4'b0000, 2'd1, 0, 0);
    step(0, 1, 0, 2'd0, 4'd0, 4'b0000, 2'd1, 0, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 1);
    // Restart mid-scan at 1 with dwell=2: each index held 3 cycles.
    step(1, 1, 1, 2'd1, 4'd2, 4'b0010, 2'd1, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b1000, 2'd3, 1, 0);
    // Load on the advance cycle of index 3: restart wins, so no wrap.
    step(1, 1, 1, 2'd0, 4'd0, 4'b0001, 2'd0, 1, 0);
    step(1, 1, 0, 2'd0, 4'd0, 4'b0010, 2'd1, 1, 0);
`else
    // Without the scan build, mode and load have no effect.
    step(1, 1, 1, 2'd2, 4'd1, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd3, 4'd0, 4'b1000, 2'd3, 1, 0);
    step(1, 1, 1, 2'd1, 4'd2, 4'b0010, 2'd1, 1, 0);
`endif

    // Asynchronous reset mid-operation, checked before any clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("reset_async");
    @(negedge clk);
    rst = 1'b0;

`ifdef DEC_SEQ_SCAN_EN
    step(1, 1, 0, 2'd2, 4'd1, 4'b0000, 2'd0, 0, 0);
    step(1, 1, 0, 2'd3, 4'd1, 4'b0000, 2'd0, 0, 0);
    step(1, 1, 0, 2'd1, 4'd1, 4'b0000, 2'd0, 0, 0);
`else
    step(1, 1, 0, 2'd2, 4'd1, 4'b0100, 2'd2, 1, 0);
    step(1, 1, 0, 2'd3, 4'd1, 4'b1000, 2'd3, 1, 0);
`endif
    step(1, 0, 0, 2'd2, 4'd0, 4'b0100, 2'd2, 1, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
